bram_rd_stream: RTL and testbench
=================================

// Module: bram_rd_stream
// PURPOSE
// - Read-side sequencer for a single-port buffer BRAM (1-cycle registered read) in the GEMM core.
// - On start, reads len consecutive words from base_addr and presents them as a valid/ready stream.
// - Feeds the GEMM datapath. A 2-entry skid FIFO absorbs the BRAM read latency, so backpressure
//   never drops or duplicates a word.
// PARAMETERS
// - WIDTH   128   data word width; must match the BRAM WIDTH
// - DEPTH   1024  BRAM depth in words
// - ADDR_W  10    address width; must equal clog2(DEPTH)
// PORTS
// - clk        in   1         sole clock; all logic on posedge
// - rst_n      in   1         asynchronous, active-low reset
// - start      in   1         launch request; sampled only in IDLE
// - base_addr  in   ADDR_W    first word address; captured on accepted start
// - len        in   ADDR_W+1  word count 0..DEPTH; captured on accepted start
// - busy       out  1         high from the cycle after an accepted start until done
// - done       out  1         1-cycle pulse at the end of a transfer
// - mem_en     out  1         BRAM enable (read only; the BRAM we is tied low by the parent)
// - mem_addr   out  ADDR_W    BRAM address
// - mem_dout   in   WIDTH     BRAM read data, valid the cycle after mem_en
// - out_valid  out  1         stream data valid
// - out_ready  in   1         stream consumer ready
// - out_data   out  WIDTH     stream data
// - out_last   out  1         marks the final word of the transfer
// BEHAVIOUR
// - Reset values: busy=0, done=0, mem_en=0, mem_addr=0, out_valid=0, out_last=0, out_data=0.
//   FIFO is emptied, the in-flight flag is cleared and the FSM goes to IDLE.
// - Reset mid-transfer aborts immediately. The pending BRAM read is discarded and no done pulse is produced.
// - FSM states: IDLE, RUN, DRAIN.
//   - IDLE: on start with len!=0, capture base_addr/len, clear the issue and beat counters, go to RUN.
//   - IDLE: on start with len==0, go to IDLE and pulse done the next cycle. No mem_en and no beats.
//   - RUN: issue reads. When issued count reaches len, go to DRAIN.
//   - DRAIN: wait until beat count reaches len, then pulse done, drop busy and return to IDLE.
//   - done and the busy fall occur in the cycle after the last-beat handshake.
// - start outside IDLE is ignored, with no effect on the current transfer.
// - Read issue in RUN: mem_en=1 when occ + inflight - pop < 2, where
//   occ = FIFO count, inflight = mem_en of the previous cycle, pop = out_valid & out_ready.
// - mem_addr = base_addr + issued, truncated to ADDR_W bits. The address wraps DEPTH-1 -> 0.
// - Capture: a word is pushed into the FIFO the cycle after each mem_en=1, taken from mem_dout.
//   mem_dout is never sampled otherwise; the BRAM holds stale data when en=0.
// - Throughput: with out_ready held high, sustains 1 word/clk.
//   First out_valid appears 2 cycles after the accepted start (1 cycle FSM entry + 1 cycle BRAM latency).
// - Stream rules:
//   - out_valid=1 iff the FIFO is non-empty; out_data is the FIFO head.
//   - While out_valid & !out_ready, out_data and out_last hold stable.
//   - out_last=1 iff the head word is beat index len-1.
// - Simultaneous push and pop is allowed at any occupancy. FIFO overflow is impossible by the issue rule.
// - len==DEPTH reads every word exactly once. A base_addr near the end of memory wraps.
// - Counters are ADDR_W+1 bits wide so len=DEPTH terminates correctly.
// TESTING
// - Basic: base=5, len=4, out_ready=1 -> mem_addr 5,6,7,8 on consecutive cycles.
//   Data words 5..8 appear in order, last on word 8, done 1 cycle after it.
// - Backpressure: len=8, out_ready toggled 1/0 randomly -> all 8 words in order, none lost or duplicated.
//   out_data stays stable while stalled, and mem_en is never issued with occ+inflight-pop>=2.
// - Wrap: base=1022, len=4 -> addresses 1022,1023,0,1; data matches the preloaded BRAM contents.
// - Edge lengths: len=0 -> done pulses with no mem_en and no out_valid.
//   len=1024 from base=0 -> 1024 beats, last only on beat 1023.
// - Reset/start abuse: assert start while busy -> ignored.
//   Pull rst_n low mid-transfer with the FIFO full -> all outputs are 0 at once.
//   A new start after reset completes normally.
// - Stall at the end: len=3 with out_ready=0 until the FIFO fills -> mem_en stops after 2 issues.
//   Releasing ready drains all 3 words, then done pulses.

Source files
------------

// File: rtl/bram_rd_stream.sv
// bram_rd_stream: read-side sequencer for a single-port buffer BRAM with a
// one-cycle registered read. On start it reads len consecutive words from
// base_addr and presents them as a valid/ready stream with a last marker.
// A 2-entry skid FIFO absorbs the BRAM read latency so that backpressure
// never drops or duplicates a word.
module bram_rd_stream #(
    parameter int WIDTH  = 128,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last
);

    // The address counter wraps by truncation, so the address width has to
    // cover exactly the BRAM depth.
    generate
        if (ADDR_W != $clog2(DEPTH)) begin : g_bad_params
            $error("bram_rd_stream: ADDR_W must equal clog2(DEPTH)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state;

    // Transfer context captured on an accepted start. Counters are one bit
    // wider than the address so that a full-depth transfer can be counted.
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   issued;
    logic [ADDR_W:0]   beats;

    // A read was issued last cycle; its data is on mem_dout this cycle.
    logic inflight;

    // Two-entry skid FIFO.
    logic [WIDTH-1:0] fifo_mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       occ;

    logic       push;
    logic       pop;
    logic       issue;
    logic       last_beat;
    logic [2:0] pending;

    // Words that will sit in the FIFO after this edge if no new read is
    // issued: stored words, plus the word landing from the BRAM, minus the
    // word leaving on a handshake. A read is issued only when that leaves
    // room, which is what keeps the 2-entry FIFO from ever overflowing
    // while still allowing one word per clock with the consumer ready.
    assign pop       = out_valid & out_ready;
    assign push      = inflight;
    assign pending   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == RUN) && (pending < 3'd2);
    assign mem_en    = issue;
    assign mem_addr  = base_r + issued[ADDR_W-1:0];

    // The stream side is the FIFO head. The beat counter equals the index of
    // the head word, which identifies the final word of the transfer.
    assign out_valid = (occ != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];
    assign out_last  = out_valid && (beats == len_r - 1'b1);
    assign last_beat = pop && out_last;

    // Transfer sequencer: launch, issue reads, wait for the stream to drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            base_r <= '0;
            len_r  <= '0;
            issued <= '0;
            beats  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            base_r <= base_addr;
                            len_r  <= len;
                            issued <= '0;
                            beats  <= '0;
                            busy   <= 1'b1;
                            state  <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        issued <= issued + 1'b1;
                        if (issued + 1'b1 == len_r) begin
                            state <= DRAIN;
                        end
                    end
                    if (pop) begin
                        beats <= beats + 1'b1;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        beats <= beats + 1'b1;
                        if (last_beat) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Skid FIFO: capture BRAM data the cycle after each read, release on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (push) begin
                fifo_mem[wr_ptr] <= mem_dout;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bram_rd_stream.sv
// tb_bram_rd_stream: randomized scoreboard bench for bram_rd_stream. A BRAM
// model with random contents answers the reads; each transfer pushes its
// expected addresses and words into queues, and a negedge monitor pops and
// compares them as the DUT issues reads and completes handshakes.
module tb_bram_rd_stream;

    localparam int WIDTH  = 128;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_dout;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_last;

    logic [WIDTH-1:0] bram [DEPTH];
    beat_t            exp_q[$];
    int               addr_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cyc    = 0;
    int ready_pct   = 100;
    int stall_left  = 0;
    bit xfer_done   = 1'b0;
    bit zero_done_ok = 1'b0;

    // Monitor state: the bench's own view of FIFO occupancy and stall holding.
    int               occ_m     = 0;
    bit               prev_en   = 1'b0;
    bit               hold_v    = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;
    logic             hold_last = 1'b0;
    bit               done_due  = 1'b0;
    bit               mon_pop;
    bit               next_due;
    beat_t            mon_e;

    bram_rd_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used for latency and throughput checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port BRAM read model: registered read, holds stale data when idle.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= bram[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic noteFail(input string name, input string detail);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    task automatic driveReady();
        if (stall_left > 0) begin
            stall_left--;
            out_ready = 1'b0;
        end else begin
            out_ready = ($urandom_range(99) < ready_pct);
        end
    endtask

    // Monitor: checks every read issue, every handshake and every done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            occ_m    = 0;
            prev_en  = 1'b0;
            hold_v   = 1'b0;
            done_due = 1'b0;
        end else begin
            mon_pop  = out_valid && out_ready;
            next_due = 1'b0;
            checkOutput("valid_vs_occupancy", out_valid, occ_m != 0);
            if (mem_en) begin
                checkOutput("issue_rule", (occ_m + int'(prev_en) - int'(mon_pop)) < 2, 1);
                if (addr_q.size() == 0)
                    noteFail("extra_mem_en", $sformatf("read of 0x%0h with none pending", mem_addr));
                else
                    checkOutput("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (hold_v) begin
                checkOutput("stall_data", out_data, hold_data);
                checkOutput("stall_last", out_last, hold_last);
            end
            if (mon_pop) begin
                if (exp_q.size() == 0) begin
                    noteFail("extra_beat", $sformatf("beat 0x%0h with none expected", out_data));
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("beat_data", out_data, mon_e.data);
                    checkOutput("beat_last", out_last, mon_e.last);
                    next_due = mon_e.last;
                end
            end
            if (done_due) begin
                checkOutput("done_pulse", done, 1);
                checkOutput("busy_fall", busy, 0);
                xfer_done = 1'b1;
                done_cyc  = cyc;
            end else if (!zero_done_ok) begin
                checkOutput("no_spurious_done", done, 0);
            end
            occ_m     = occ_m + int'(prev_en) - int'(mon_pop);
            prev_en   = mem_en;
            hold_v    = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
            done_due  = next_due;
        end
    end

    task automatic resetDut();
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One transfer: queue expectations from the BRAM contents, launch, feed
    // ready, and wait (bounded) for the done pulse.
    task automatic applyStimulus(input int base, input int n, input int pct,
                                 input int stall, input bit abuse);
        beat_t e;
        int    cycles;
        int    c0;
        for (int i = 0; i < n; i++) begin
            e.data = bram[(base + i) % DEPTH];
            e.last = (i == n - 1);
            exp_q.push_back(e);
            addr_q.push_back((base + i) % DEPTH);
        end
        ready_pct  = pct;
        stall_left = stall;
        xfer_done  = 1'b0;
        if (n == 0) zero_done_ok = 1'b1;
        @(posedge clk);
        #2;
        start     = 1'b1;
        base_addr = base[ADDR_W-1:0];
        len       = n[ADDR_W:0];
        driveReady();
        @(posedge clk);
        #2;
        start = 1'b0;
        c0    = cyc;
        driveReady();
        if (n == 0) begin
            @(negedge clk);
            #1;
            checkOutput("zero_len_done", done, 1);
            checkOutput("zero_len_no_en", mem_en, 0);
            checkOutput("zero_len_no_valid", out_valid, 0);
            zero_done_ok = 1'b0;
            repeat (4) @(posedge clk);
            #2;
            return;
        end
        checkOutput("busy_after_start", busy, 1);
        checkOutput("valid_latency_0", out_valid, 0);
        @(posedge clk);
        #2;
        checkOutput("valid_latency_1", out_valid, 0);
        driveReady();
        @(posedge clk);
        #2;
        checkOutput("valid_latency_2", out_valid, 1);
        driveReady();
        cycles = 0;
        while (!xfer_done && cycles < 30 * n + 100) begin
            @(posedge clk);
            #2;
            cycles++;
            if (stall > 0 && stall_left == 1) begin
                checkOutput("stall_issue_count", n - addr_q.size(), 2);
                checkOutput("stall_fifo_full", out_valid, 1);
                checkOutput("stall_no_en", mem_en, 0);
            end
            start = abuse && (cycles == 2);
            if (start) begin
                base_addr = ADDR_W'($urandom());
                len       = (ADDR_W + 1)'($urandom_range(50, 1));
            end
            driveReady();
        end
        start = 1'b0;
        if (!xfer_done) begin
            noteFail("timeout", $sformatf("no done after %0d cycles, %0d beats left", cycles, exp_q.size()));
            resetDut();
        end else if (pct == 100 && stall == 0) begin
            checkOutput("throughput", done_cyc - c0, n + 2);
        end
        checkOutput("all_beats_seen", exp_q.size(), 0);
        checkOutput("all_reads_seen", addr_q.size(), 0);
        exp_q.delete();
        addr_q.delete();
    endtask

    // Launch a long transfer, let the FIFO fill under backpressure, then
    // pull reset and verify every output clears immediately.
    task automatic resetMidTransfer(input int base);
        beat_t e;
        for (int i = 0; i < 64; i++) begin
            e.data = bram[(base + i) % DEPTH];
            e.last = (i == 63);
            exp_q.push_back(e);
            addr_q.push_back((base + i) % DEPTH);
        end
        @(posedge clk);
        #2;
        start     = 1'b1;
        base_addr = base[ADDR_W-1:0];
        len       = 11'd64;
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checkOutput("pre_reset_valid", out_valid, 1);
        checkOutput("pre_reset_no_en", mem_en, 0);
        checkOutput("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_out_data", out_data, 0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++)
            bram[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        rst_n     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_mem_en", mem_en, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_out_data", out_data, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        applyStimulus(5, 4, 100, 0, 1'b0);
        for (int k = 0; k < 3; k++)
            applyStimulus(int'($urandom_range(DEPTH - 1)), 8, 50, 0, 1'b0);
        applyStimulus(1022, 4, 100, 0, 1'b0);
        applyStimulus(17, 0, 100, 0, 1'b0);
        applyStimulus(0, 1024, 100, 0, 1'b0);
        applyStimulus(int'($urandom_range(DEPTH - 1)), 16, 70, 0, 1'b1);
        resetMidTransfer(300);
        applyStimulus(100, 10, 100, 0, 1'b0);
        applyStimulus(7, 3, 100, 8, 1'b0);
        for (int k = 0; k < 12; k++) begin
            int n;
            n = int'($urandom_range(40, 1));
            applyStimulus(int'($urandom_range(DEPTH - 1)), n, int'($urandom_range(100, 30)),
                          0, (n >= 8) && $urandom_range(1));
        end
        applyStimulus(700, 1024, 60, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
